shiftadd_seq_reduce: RTL and testbench

//  Multi-cycle shift-add reducer: r = x mod m for special moduli m = 2^k-1 (Mersenne) or 2^k+1 (Fermat).

---
 rtl/shiftadd_pkg.sv | 21 ++
 rtl/shiftadd_fold_step.sv | 44 ++++
 rtl/shiftadd_seq_reduce.sv | 141 ++++++++++++++
 tb/tb_shiftadd_seq_reduce.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/shiftadd_pkg.sv
// Shared types and constants for the shift-add special-modulus reducers.
// Imported by the sequential reducer and the combinational fold step.
package shiftadd_pkg;

    // Smallest exponent for which 2^k-1 / 2^k+1 is a useful modulus.
    localparam int K_MIN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FOLD,
        S_CORR,
        S_DONE
    } sa_state_e;

    typedef enum logic {
        MOD_MERSENNE,
        MOD_FERMAT
    } sa_kind_e;

endpackage

// File: rtl/shiftadd_fold_step.sv
// One fold of a signed accumulator modulo 2^k-1 or 2^k+1.
// Splits acc into lo = acc[k-1:0] (unsigned) and hi = acc >>> k, then forms
// lo + hi (Mersenne, since 2^k == 1) or lo - hi (Fermat, since 2^k == -1).
// fold_done reports that acc is already reduced far enough for the final
// correction; it is evaluated on the incoming acc.
module shiftadd_fold_step
    import shiftadd_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int KW     = 7
) (
    input  logic signed [DATA_W+1:0] acc,
    input  logic        [KW-1:0]     k,
    input  sa_kind_e                 kind,
    output logic signed [DATA_W+1:0] acc_next,
    output logic                     fold_done
);

    localparam int ACC_W = DATA_W + 2;

    logic        [ACC_W-1:0] lo_mask;
    logic signed [ACC_W-1:0] lo;
    logic signed [ACC_W-1:0] hi;

    // Split the accumulator at bit k and recombine with the modulus-specific sign.
    always_comb begin
        // NOTE: every output gets a default first so no path can leave a value held (no latch).
        acc_next  = acc;
        fold_done = 1'b0;

        lo_mask = ~({ACC_W{1'b1}} << k);
        lo      = $signed(acc & lo_mask);
        hi      = acc >>> k;

        if (kind == MOD_FERMAT) begin
            acc_next  = lo - hi;
            fold_done = (hi == '0) || (hi == {ACC_W{1'b1}});
        end else begin
            acc_next  = lo + hi;
            fold_done = (hi == '0);
        end
    end

endmodule

// File: rtl/shiftadd_seq_reduce.sv
// Multi-cycle shift-add reducer: result = x mod (2^k-1) or x mod (2^k+1).
// Responds to a start/busy/finish handshake. The operand is folded k bits per
// cycle through one shared fold step, then a single correction brings the
// value into [0, m-1]. All outputs are registered.
module shiftadd_seq_reduce
    import shiftadd_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int KW     = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              kind_i,
    input  logic [KW-1:0]     k_i,
    input  logic [DATA_W-1:0] x_i,
    output logic              busy_o,
    output logic              finish_o,
    output logic              err_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int ACC_W = DATA_W + 2;

    // Legal exponent window [K_MIN, DATA_W-1] at the width of k.
    localparam logic [KW-1:0] K_LO = KW'(K_MIN);
    localparam logic [KW-1:0] K_HI = KW'(DATA_W - 1);

    sa_state_e               state;
    logic [DATA_W-1:0]       x_q;
    logic [KW-1:0]           k_q;
    sa_kind_e                kind_q;
    logic signed [ACC_W-1:0] acc;

    logic                    k_ok;
    logic [ACC_W-1:0]        pow_k;
    logic signed [ACC_W-1:0] modulus;
    logic signed [ACC_W-1:0] acc_fold;
    logic                    fold_done;
    logic signed [ACC_W-1:0] acc_corr;

    // Shared fold datapath, also used by the parallel reducer.
    shiftadd_fold_step #(
        .DATA_W (DATA_W),
        .KW     (KW)
    ) u_fold (
        .acc       (acc),
        .k         (k_q),
        .kind      (kind_q),
        .acc_next  (acc_fold),
        .fold_done (fold_done)
    );

    // Range check on the latched exponent and the modulus it implies.
    always_comb begin
        k_ok    = (k_q >= K_LO) && (k_q <= K_HI);
        pow_k   = {{(ACC_W-1){1'b0}}, 1'b1} << k_q;
        modulus = (kind_q == MOD_FERMAT) ? $signed(pow_k + ACC_W'(1))
                                         : $signed(pow_k - ACC_W'(1));
    end

    // Final correction: Mersenne maps m to 0, Fermat lifts negatives by m.
    always_comb begin
        acc_corr = acc;
        if (kind_q == MOD_FERMAT) begin
            if (acc[ACC_W-1]) begin
                acc_corr = acc + modulus;
            end
        end else begin
            if (acc == modulus) begin
                acc_corr = '0;
            end
        end
    end

    // Control FSM with registered handshake outputs; synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
        if (!rst_ni) begin
            state    <= S_IDLE;
            busy_o   <= 1'b0;
            finish_o <= 1'b0;
            err_o    <= 1'b0;
            result_o <= '0;
            x_q      <= '0;
            k_q      <= '0;
            kind_q   <= MOD_MERSENNE;
            acc      <= '0;
        end else begin
            finish_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        x_q    <= x_i;
                        k_q    <= k_i;
                        kind_q <= sa_kind_e'(kind_i);
                        busy_o <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!k_ok) begin
                        acc      <= '0;
                        result_o <= '0;
                        err_o    <= 1'b1;
                        busy_o   <= 1'b0;
                        finish_o <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        acc   <= $signed({2'b00, x_q});
                        state <= S_FOLD;
                    end
                end
                S_FOLD: begin
                    // The exit cycle only tests; it never applies a fold.
                    if (fold_done) begin
                        state <= S_CORR;
                    end else begin
                        acc <= acc_fold;
                    end
                end
                S_CORR: begin
                    acc      <= acc_corr;
                    result_o <= acc_corr[DATA_W-1:0];
                    err_o    <= 1'b0;
                    busy_o   <= 1'b0;
                    finish_o <= 1'b1;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shiftadd_seq_reduce.sv
// Scoreboard bench for shiftadd_seq_reduce: the stimulus pushes hand-computed
// expectations, a negedge monitor pops them whenever finish_o is seen.
module tb_shiftadd_seq_reduce;

    localparam int DATA_W = 64;
    localparam int KW     = 7;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              start_i;
    logic              kind_i;
    logic [KW-1:0]     k_i;
    logic [DATA_W-1:0] x_i;
    logic              busy_o;
    logic              finish_o;
    logic              err_o;
    logic [DATA_W-1:0] result_o;

    shiftadd_seq_reduce #(
        .DATA_W (DATA_W),
        .KW     (KW)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .kind_i   (kind_i),
        .k_i      (k_i),
        .x_i      (x_i),
        .busy_o   (busy_o),
        .finish_o (finish_o),
        .err_o    (err_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    int n_tests      = 0;
    int n_fail       = 0;
    int cyc          = 0;
    int finish_count = 0;

    typedef struct {
        string       name;
        logic [63:0] res;
        logic [63:0] model;
        logic        err;
        int          lat;
        int          accept_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops on finish_o, checks pulse width and result hold window.
    logic        holding       = 1'b0;
    logic        width_pending = 1'b0;
    logic [63:0] held_res;
    logic [63:0] seen_res;
    logic        held_err;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_ni) begin
            holding       = 1'b0;
            width_pending = 1'b0;
        end else begin
            if (width_pending) begin
                check("finish_width", finish_o, 1'b0);
                width_pending = 1'b0;
            end
            if (holding && !finish_o) begin
                if (busy_o) begin
                    check("result_stable", seen_res, held_res);
                    holding = 1'b0;
                end else if ((result_o !== held_res || err_o !== held_err) && seen_res === held_res) begin
                    seen_res = result_o;
                end
            end
            if (finish_o) begin
                finish_count++;
                width_pending = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_finish", finish_o, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, result_o, e.res);
                    check({e.name, "_x_mod_m"}, result_o, e.model);
                    check({e.name, "_err"}, err_o, e.err);
                    if (e.lat > 0) check({e.name, "_latency"}, 64'(cyc - e.accept_cyc), 64'(e.lat));
                end
                holding  = 1'b1;
                held_res = result_o;
                held_err = err_o;
                seen_res = result_o;
            end
        end
    end

    // Issue one operation; lat is edges from accept to finish_o (0 = not checked).
    task automatic run_op(input string name, input logic kind, input int k, input logic [63:0] x,
                          input logic [63:0] res, input logic err, input int lat, input logic poke);
        logic [65:0] m;
        exp_t        e;
        int          f0;
        int          guard;
        guard = 0;
        @(negedge clk);
        while ((busy_o || finish_o) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        start_i = 1'b1;
        kind_i  = kind;
        k_i     = KW'(k);
        x_i     = x;
        @(posedge clk);
        #1;
        e.name       = name;
        e.res        = res;
        e.err        = err;
        e.lat        = lat;
        e.accept_cyc = cyc;
        e.model      = 64'd0;
        if (!err) begin
            m = 66'd1 << k;
            m = kind ? m + 66'd1 : m - 66'd1;
            e.model = 64'({2'b00, x} % m);
        end
        sb.push_back(e);
        f0      = finish_count;
        start_i = 1'b0;
        x_i     = ~x;
        kind_i  = ~kind;
        if (poke) begin
            @(negedge clk);
            start_i = 1'b1;
            x_i     = 64'h7FFF_FFFF;
            @(negedge clk);
            start_i = 1'b0;
        end
        for (int i = 0; i < 300 && finish_count == f0; i++) @(negedge clk);
        check({name, "_finished"}, 64'(finish_count - f0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int f0;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        kind_i  = 1'b0;
        k_i     = '0;
        x_i     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy_o, 1'b0);
        check("reset_finish", finish_o, 1'b0);
        check("reset_err", err_o, 1'b0);
        check("reset_result", result_o, 64'd0);
        rst_ni = 1'b1;

        // kind: 0 = Mersenne, 1 = Fermat; latency = 3 + number of folds.
        run_op("fermat_k31_ones",   1'b1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3,               1'b0, 5, 1'b0);
        run_op("mersenne_k31_2p32", 1'b0, 31, 64'h1_0000_0000,         64'h2,               1'b0, 4, 1'b0);
        run_op("mersenne_x_eq_m",   1'b0, 31, 64'h7FFF_FFFF,           64'h0,               1'b0, 3, 1'b0);
        run_op("fermat_k31_2p32",   1'b1, 31, 64'h1_0000_0000,         64'h7FFF_FFFF,       1'b0, 4, 1'b0);
        // 2^31 folds once to acc = -1, which corrects to 2^k.
        run_op("fermat_acc_m1",     1'b1, 31, 64'h8000_0000,           64'h8000_0000,       1'b0, 4, 1'b0);
        run_op("fermat_x_eq_m",     1'b1, 31, 64'h8000_0001,           64'h0,               1'b0, 4, 1'b0);
        run_op("mersenne_k63",      1'b0, 63, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,               1'b0, 5, 1'b0);
        run_op("fermat_k63",        1'b1, 63, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFE, 1'b0, 4, 1'b0);
        run_op("mersenne_x_zero",   1'b0, 5,  64'h0,                   64'h0,               1'b0, 3, 1'b0);
        run_op("mersenne_k2",       1'b0, 2,  64'd63,                  64'h0,               1'b0, 6, 1'b0);
        run_op("fermat_k2",         1'b1, 2,  64'd100,                 64'h0,               1'b0, 6, 1'b0);
        run_op("mersenne_k7",       1'b0, 7,  64'd1000,                64'd111,             1'b0, 4, 1'b0);
        run_op("err_k1",            1'b0, 1,  64'h1234,                64'h0,               1'b1, 0, 1'b0);
        run_op("err_k64",           1'b1, 64, 64'h5678,                64'h0,               1'b1, 0, 1'b0);
        run_op("ignored_start",     1'b0, 31, 64'h1_0000_0000,         64'h2,               1'b0, 4, 1'b1);

        // Abort a long Mersenne k=2 operation with a one-cycle reset during FOLD.
        @(negedge clk);
        while (busy_o || finish_o) @(negedge clk);
        start_i = 1'b1;
        kind_i  = 1'b0;
        k_i     = KW'(2);
        x_i     = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        f0      = finish_count;
        repeat (4) @(negedge clk);
        check("abort_busy_before_reset", busy_o, 1'b1);
        rst_ni = 1'b0;
        @(negedge clk);
        check("abort_busy", busy_o, 1'b0);
        check("abort_finish", finish_o, 1'b0);
        check("abort_err", err_o, 1'b0);
        check("abort_result", result_o, 64'd0);
        rst_ni = 1'b1;
        repeat (60) @(negedge clk);
        check("abort_no_finish", 64'(finish_count - f0), 64'd0);

        run_op("after_reset",       1'b0, 7,  64'd1000,                64'd111,             1'b0, 4, 1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
